au_digit_serial_adder: RTL

Parametrised digit-serial adder/subtractor for the arithmetic-unit library. It accepts two WIDTH-bit operands through a valid/ready handshake and adds them DIGIT bits per clock, LSB digit first, with a registered carry between digits. It presents the sum, carry-out and signed overflow through a second valid/ready handshake. It trades latency for area in datapaths where a full-width adder is too large.

---
 rtl/au_pkg.sv | 21 ++
 rtl/au_digit_serial_adder_if.sv | 29 ++
 rtl/au_digit_adder.sv | 25 ++
 rtl/au_digit_serial_adder.sv | 124 ++++++++++++
 4 files changed

// File: rtl/au_pkg.sv
// rtl/au_pkg.sv - shared arithmetic-unit types and helpers
// Contents: state_t (IDLE/RUN/DONE) FSM encoding; clog2() ceiling log2 for
// constant sizing.
package au_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/au_digit_serial_adder_if.sv
// rtl/au_digit_serial_adder_if.sv - operand/result handshake bundle for the digit-serial adder
// Signals: in_valid/in_ready + a, b, ci, sub (operand side);
//          out_valid/out_ready + s, co, ovf (result side).
// master drives operands and out_ready; slave is the adder.
interface au_digit_serial_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, s, co, ovf
    );

    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, s, co, ovf
    );
endinterface

// File: rtl/au_digit_adder.sv
// rtl/au_digit_adder.sv - DIGIT-bit ripple-carry adder built from full-adder cells
// Ports: x, y (DIGIT) operands; cin carry-in; sum (DIGIT); cout carry out of
// the top bit; c_msb carry into the top bit (for signed overflow).
module au_digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum[i]  = x[i] ^ y[i] ^ c[i];
        assign c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];
endmodule

// File: rtl/au_digit_serial_adder.sv
// rtl/au_digit_serial_adder.sv - digit-serial adder/subtractor, LSB digit first, N=WIDTH/DIGIT cycles per op
// Ports: clk; rst (sync, active-high); bus (slave modport) carrying the
// operand handshake (in_valid/in_ready, a, b, ci, sub) and the result
// handshake (out_valid/out_ready, s, co, ovf).
module au_digit_serial_adder
    import au_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    au_digit_serial_adder_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? clog2(N) : 1;

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("au_digit_serial_adder: illegal WIDTH/DIGIT combination");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0]       dsum;
    logic                   dcout, dcmsb;
    logic                   accept, last;
    logic [WIDTH+DIGIT-1:0] sr_cat;

    au_digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x     (a_q[DIGIT-1:0]),
        .y     (b_q[DIGIT-1:0]),
        .cin   (carry_q),
        .sum   (dsum),
        .cout  (dcout),
        .c_msb (dcmsb)
    );

    // Gated by rst so no operand is taken while reset is held.
    assign bus.in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    assign accept        = bus.in_valid && bus.in_ready;
    assign last          = (cnt_q == CW'(N - 1));
    // Upper WIDTH bits are the partial sum with this digit entering at the MSB.
    assign sr_cat        = {dsum, sr_q};

    assign bus.out_valid = (state_q == DONE);
    assign bus.s         = s_q;
    assign bus.co        = co_q;
    assign bus.ovf       = ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sr_d    = sr_q;
        s_d     = s_q;
        carry_d = carry_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE && bus.out_ready) begin
                    state_d = IDLE;
                end
                if (accept) begin
                    // Subtraction is a + ~b + 1.
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.ci;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                sr_d    = sr_cat[WIDTH+DIGIT-1:DIGIT];
                carry_d = dcout;
                if (last) begin
                    // s is only updated here so it stays stable through the next RUN.
                    s_d     = sr_cat[WIDTH+DIGIT-1:DIGIT];
                    co_d    = dcout;
                    ovf_d   = dcmsb ^ dcout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sr_q    <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sr_q    <= sr_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
